// File: rtl/keypad_pkg.sv
// keypad_pkg: shared sequencer state encoding and ASCII constants for the keypad TX path
package keypad_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, GAP} seq_state_t;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0 = 8'h30;
endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: synchronous FIFO; the occupancy count tells full from empty, pointers wrap freely
module keypad_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     FPGA_CLK1_50,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge FPGA_CLK1_50)
    if (push) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/keypad_tx_sequencer.sv
// keypad_tx_sequencer: queues keypad bytes and feeds them one at a time to the UART with an
// enforced inter-byte gap, a busy-acknowledge timeout and ENTER->terminator mapping
module keypad_tx_sequencer
  import keypad_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter int          GAP_CYCLES   = 16,
  parameter int          BUSY_TIMEOUT = 1024,
  parameter logic [7:0]  ENTER_CHAR   = ASCII_HASH,
  parameter logic [7:0]  TERM_CHAR    = ASCII_CR
) (
  input  logic                     FPGA_CLK1_50,
  input  logic                     reset_n,
  input  logic                     key_valid,
  input  logic [7:0]               key_ascii,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     timeout_err,
  input  logic                     clr_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  seq_state_t state, nxt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0] rdata;
  logic full, pop, push, drop, tmo_hit, gap_done;
  assign full = fifo_count == CW'(DEPTH);
  assign pop = state == LOAD;
  // a full FIFO still accepts a key in the cycle the head is being popped
  assign push = key_valid && (!full || pop);
  assign drop = key_valid && full && !pop;
  assign tmo_hit = state == WAIT_ACK && !tx_busy && tmo_cnt == TW'(BUSY_TIMEOUT - 1);
  assign gap_done = gap_cnt == GW'(GAP_CYCLES - 1);
  keypad_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset_n      (reset_n),
    .push         (push),
    .pop          (pop),
    .wdata        (key_ascii == ENTER_CHAR ? TERM_CHAR : key_ascii),
    .rdata        (rdata),
    .count        (fifo_count)
  );
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = fifo_count != '0 ? LOAD : IDLE;
      LOAD:      nxt = START;
      START:     nxt = WAIT_ACK;
      WAIT_ACK:  nxt = tx_busy ? WAIT_DONE : tmo_hit ? GAP : WAIT_ACK;
      WAIT_DONE: nxt = tx_busy ? WAIT_DONE : GAP;
      GAP:       nxt = gap_done ? IDLE : GAP;
      default:   nxt = IDLE;
    endcase
  end
  always_comb tx_start = state == START;
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n)
    if (!reset_n) begin
      tx_data <= '0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (pop) tx_data <= rdata;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      tmo_cnt <= state == WAIT_ACK ? tmo_cnt + 1'b1 : '0;
      overflow <= drop | (overflow & ~clr_err);
      timeout_err <= tmo_hit | (timeout_err & ~clr_err);
    end
endmodule

// File: tb/tb_keypad_tx_sequencer.sv
// tb_keypad_tx_sequencer: directed scenarios with a UART responder and an expected-byte queue
module tb_keypad_tx_sequencer;
  import keypad_pkg::*;
  localparam int DEPTH = 8, GAP = 16, BT = 1024;
  logic FPGA_CLK1_50 = 1'b0, reset_n = 1'b0, key_valid = 1'b0, tx_busy = 1'b0, clr_err = 1'b0;
  logic [7:0] key_ascii = 8'h00;
  logic tx_start, overflow, timeout_err;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;
  int total = 0, bad = 0, cyc = 0, last_fall = -1000, starts = 0;
  int ack_delay = 10, busy_len = 10, um_st = 0, um_cnt = 0;
  bit ack_en = 1'b1;
  logic [7:0] exp_q[$];

  keypad_tx_sequencer dut (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset_n      (reset_n),
    .key_valid    (key_valid),
    .key_ascii    (key_ascii),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .clr_err      (clr_err)
  );

  always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // byte scoreboard on every tx_start, then the UART responder
  always @(negedge FPGA_CLK1_50) begin
    cyc++;
    if (reset_n && tx_start) begin
      starts++;
      chk("start_gap", 32'(cyc - last_fall >= GAP), 1);
      chk("no_hash_sent", 32'(tx_data != ASCII_HASH), 1);
      chk("start_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
    end
    if (!reset_n) begin
      um_st = 0;
      tx_busy = 1'b0;
    end else if (um_st == 0) begin
      if (tx_start && ack_en) begin
        um_st = 1;
        um_cnt = 0;
      end
    end else if (um_st == 1) begin
      if (++um_cnt >= ack_delay) begin
        tx_busy = 1'b1;
        um_st = 2;
        um_cnt = 0;
      end
    end else if (++um_cnt >= busy_len) begin
      tx_busy = 1'b0;
      last_fall = cyc;
      um_st = 0;
    end
  end

  task automatic key(input logic [7:0] c, input bit expect_it = 1'b1);
    key_valid = 1'b1;
    key_ascii = c;
    if (expect_it) exp_q.push_back(c == ASCII_HASH ? ASCII_CR : c);
    @(negedge FPGA_CLK1_50);
    key_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge FPGA_CLK1_50);
      n++;
    end
    chk(tag, 32'(n < 100), 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0 || tx_busy) && n < 4000) begin
      @(negedge FPGA_CLK1_50);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (30) @(negedge FPGA_CLK1_50);
  endtask

  initial begin
    int n, s0;
    repeat (3) @(negedge FPGA_CLK1_50);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;
    @(negedge FPGA_CLK1_50);
    // single key, latency from key_valid to tx_start
    key(8'h35);
    n = 1;
    while (!tx_start && n < 60) begin
      @(negedge FPGA_CLK1_50);
      n++;
    end
    chk("t1_latency", n, 3);
    chk("t1_count_after_pop", fifo_count, 0);
    drain("t1_drain");
    // fill the FIFO while a long byte is on the wire
    busy_len = 60;
    key(8'h41);
    wait_busy("t2_ack");
    for (int i = 0; i < DEPTH; i++) key(ASCII_0 + 8'(i));
    chk("t2_count_full", fifo_count, 8);
    chk("t2_no_overflow", overflow, 0);
    key(8'h38, 1'b0);
    chk("t3_overflow_set", overflow, 1);
    chk("t3_count_still_full", fifo_count, 8);
    clr_err = 1'b1;
    @(negedge FPGA_CLK1_50);
    clr_err = 1'b0;
    chk("t3_overflow_clr", overflow, 0);
    drain("t2_drain");
    busy_len = 10;
    // ENTER mapping
    key(ASCII_HASH);
    drain("t4_drain");
    // UART never acknowledges the first byte
    ack_en = 1'b0;
    key(8'h42);
    key(8'h43);
    n = 0;
    while (!tx_start && n < 60) begin
      @(negedge FPGA_CLK1_50);
      n++;
    end
    chk("t5_start_seen", tx_start, 1);
    n = 0;
    while (!timeout_err && n < BT + 100) begin
      @(negedge FPGA_CLK1_50);
      n++;
    end
    chk("t5_timeout_latency", n, BT + 1);
    ack_en = 1'b1;
    drain("t5_drain");
    chk("t5_timeout_sticky", timeout_err, 1);
    // asynchronous reset mid-transfer with bytes queued
    busy_len = 60;
    key(8'h44);
    wait_busy("t6_ack");
    key(8'h45);
    key(8'h46);
    key(8'h47);
    chk("t6_count_before", fifo_count, 3);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_start", tx_start, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_timeout", timeout_err, 0);
    exp_q.delete();
    s0 = starts;
    repeat (3) @(negedge FPGA_CLK1_50);
    reset_n = 1'b1;
    busy_len = 10;
    repeat (60) @(negedge FPGA_CLK1_50);
    chk("t6_no_start_after_rst", starts - s0, 0);
    key(8'h48);
    drain("t6_drain");
    chk("t6_one_start_new_key", starts - s0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
